// File: rtl/jtag_tap_driver.sv
// jtag_tap_driver: JTAG initiator that shifts up to MAX_LEN TMS/TDI bits per
// command into a TAP and returns the TDO bits it captured. TCK runs at
// clk_i / (2*CLK_DIV). TMS and TDI change only on the falling TCK edge.
// TDO is synchronised and sampled on the last clk_i cycle before TCK falls.
module jtag_tap_driver #(
    parameter int CLK_DIV = 4,
    parameter int MAX_LEN = 32,
    parameter int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [LW-1:0]      cmd_len_i,
    input  logic [MAX_LEN-1:0] cmd_tms_i,
    input  logic [MAX_LEN-1:0] cmd_tdi_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [MAX_LEN-1:0] rsp_tdo_o,
    output logic               jtag_tck_o,
    output logic               jtag_tms_o,
    output logic               jtag_tdi_o,
    output logic               jtag_trst_no,
    input  logic               jtag_tdo_i
);

    localparam int            CW       = $clog2(CLK_DIV);
    localparam int            IW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_RSP
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [IW-1:0]      r_idx;
    logic [LW-1:0]      r_len;
    logic [MAX_LEN-1:0] r_tms_v;
    logic [MAX_LEN-1:0] r_tdi_v;
    logic [MAX_LEN-1:0] r_cap;
    logic               r_tck;
    logic               r_tms;
    logic               r_tdi;
    logic               r_trst_n;
    logic               r_cmd_ready;
    logic               r_rsp_valid;
    logic [MAX_LEN-1:0] r_rsp_tdo;
    logic               r_tdo_s1;
    logic               r_tdo_s2;

    state_t             w_state_n;
    logic [CW-1:0]      w_cnt_n;
    logic [IW-1:0]      w_idx_n;
    logic [LW-1:0]      w_len_n;
    logic [MAX_LEN-1:0] w_tms_v_n;
    logic [MAX_LEN-1:0] w_tdi_v_n;
    logic [MAX_LEN-1:0] w_cap_n;
    logic               w_tck_n;
    logic               w_tms_n;
    logic               w_tdi_n;
    logic               w_cmd_ready_n;
    logic               w_rsp_valid_n;
    logic [MAX_LEN-1:0] w_rsp_tdo_n;
    logic [LW-1:0]      w_len_clamp;
    logic [IW-1:0]      w_idx_inc;
    logic               w_last_bit;

    assign w_len_clamp = (cmd_len_i > LEN_MAX) ? LEN_MAX : cmd_len_i;
    assign w_idx_inc   = r_idx + IW'(1);
    assign w_last_bit  = ((LW'(r_idx) + LW'(1)) == r_len);

    // Next-state and next-output logic; every output is registered from here
    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_idx_n       = r_idx;
        w_len_n       = r_len;
        w_tms_v_n     = r_tms_v;
        w_tdi_v_n     = r_tdi_v;
        w_cap_n       = r_cap;
        w_tck_n       = r_tck;
        w_tms_n       = r_tms;
        w_tdi_n       = r_tdi;
        w_rsp_valid_n = r_rsp_valid;
        w_rsp_tdo_n   = r_rsp_tdo;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid_i && r_cmd_ready) begin
                    w_len_n   = w_len_clamp;
                    w_tms_v_n = cmd_tms_i;
                    w_tdi_v_n = cmd_tdi_i;
                    w_idx_n   = '0;
                    w_cnt_n   = '0;
                    w_cap_n   = '0;
                    if (w_len_clamp == '0) begin
                        w_state_n     = ST_RSP;
                        w_rsp_valid_n = 1'b1;
                        w_rsp_tdo_n   = '0;
                    end else begin
                        w_state_n = ST_LO;
                        w_tms_n   = cmd_tms_i[0];
                        w_tdi_n   = cmd_tdi_i[0];
                    end
                end
            end
            ST_LO: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_n   = '0;
                    w_tck_n   = 1'b1;
                    w_state_n = ST_HI;
                end else begin
                    w_cnt_n = r_cnt + CW'(1);
                end
            end
            ST_HI: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_n        = '0;
                    w_tck_n        = 1'b0;
                    w_cap_n[r_idx] = r_tdo_s2;
                    if (w_last_bit) begin
                        w_state_n     = ST_RSP;
                        w_rsp_valid_n = 1'b1;
                        w_rsp_tdo_n   = w_cap_n;
                    end else begin
                        w_idx_n   = w_idx_inc;
                        w_tms_n   = r_tms_v[w_idx_inc];
                        w_tdi_n   = r_tdi_v[w_idx_inc];
                        w_state_n = ST_LO;
                    end
                end else begin
                    w_cnt_n = r_cnt + CW'(1);
                end
            end
            ST_RSP: begin
                if (rsp_ready_i) begin
                    w_state_n     = ST_IDLE;
                    w_rsp_valid_n = 1'b0;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase

        w_cmd_ready_n = (w_state_n == ST_IDLE);
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_len       <= '0;
            r_tms_v     <= '0;
            r_tdi_v     <= '0;
            r_cap       <= '0;
            r_tck       <= 1'b0;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
            r_trst_n    <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_tdo   <= '0;
            r_tdo_s1    <= 1'b0;
            r_tdo_s2    <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_idx       <= w_idx_n;
            r_len       <= w_len_n;
            r_tms_v     <= w_tms_v_n;
            r_tdi_v     <= w_tdi_v_n;
            r_cap       <= w_cap_n;
            r_tck       <= w_tck_n;
            r_tms       <= w_tms_n;
            r_tdi       <= w_tdi_n;
            r_trst_n    <= 1'b1;
            r_cmd_ready <= w_cmd_ready_n;
            r_rsp_valid <= w_rsp_valid_n;
            r_rsp_tdo   <= w_rsp_tdo_n;
            r_tdo_s1    <= jtag_tdo_i;
            r_tdo_s2    <= r_tdo_s1;
        end
    end

    assign cmd_ready_o  = r_cmd_ready;
    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_tdo_o    = r_rsp_tdo;
    assign jtag_tck_o   = r_tck;
    assign jtag_tms_o   = r_tms;
    assign jtag_tdi_o   = r_tdi;
    assign jtag_trst_no = r_trst_n;

endmodule

// File: tb/tb_jtag_tap_driver.sv
// tb_jtag_tap_driver: table-driven and randomised bench for jtag_tap_driver.
// A TDO source replays a bit pattern, advancing one bit per falling TCK edge,
// or loops TDI back. A pin monitor records TMS/TDI at each rising TCK edge and
// counts phase-width and hold violations.
module tb_jtag_tap_driver;

    localparam int CLK_DIV = 4;
    localparam int MAX_LEN = 32;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [LW-1:0]     cmd_len;
    logic [31:0]       cmd_tms;
    logic [31:0]       cmd_tdi;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_tdo;
    logic              tck;
    logic              tms;
    logic              tdi;
    logic              trst_n;
    logic              tdo;

    int total;
    int bad;

    jtag_tap_driver #(
        .CLK_DIV(CLK_DIV),
        .MAX_LEN(MAX_LEN)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_len_i   (cmd_len),
        .cmd_tms_i   (cmd_tms),
        .cmd_tdi_i   (cmd_tdi),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_tdo_o   (rsp_tdo),
        .jtag_tck_o  (tck),
        .jtag_tms_o  (tms),
        .jtag_tdi_o  (tdi),
        .jtag_trst_no(trst_n),
        .jtag_tdo_i  (tdo)
    );

    always #5 clk = ~clk;

    // TDO source: bit k of the pattern is presented after k falling TCK edges
    int          fall_cnt;
    int          fall_base;
    int          tdo_k;
    logic [63:0] tdo_pat;
    bit          loopback;

    always @(negedge tck) fall_cnt = fall_cnt + 1;

    always_comb begin
        tdo_k = fall_cnt - fall_base;
        if (loopback)
            tdo = tdi;
        else if (tdo_k >= 0 && tdo_k < 64)
            tdo = tdo_pat[tdo_k];
        else
            tdo = 1'b0;
    end

    // Pin monitor: records TMS/TDI at each rising TCK and checks phase widths
    logic prev_tck;
    logic prev_tms;
    logic prev_tdi;
    int   pulses;
    int   pulse_base;
    int   hi_len;
    int   lo_len;
    int   phase_bad;
    bit   mon_tms[$];
    bit   mon_tdi[$];

    always @(negedge clk) begin
        if (tck === 1'b1) begin
            if (prev_tck !== 1'b1) begin
                if (pulses > pulse_base && lo_len != CLK_DIV) phase_bad++;
                mon_tms.push_back(tms);
                mon_tdi.push_back(tdi);
                pulses++;
                hi_len = 1;
            end else begin
                hi_len++;
                if (tms !== prev_tms || tdi !== prev_tdi) phase_bad++;
            end
        end else begin
            if (prev_tck === 1'b1) begin
                if (hi_len != CLK_DIV) phase_bad++;
                lo_len = 1;
            end else begin
                lo_len++;
            end
        end
        prev_tck = tck;
        prev_tms = tms;
        prev_tdi = tdi;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // One complete command/response transaction, checked against the given expectations
    task automatic run_cmd(input string tag, input int len, input logic [31:0] t_tms,
                           input logic [31:0] t_tdi, input logic [63:0] pat, input bit lb,
                           input int hold, input logic [31:0] exp_rsp, input int exp_pulses);
        int          cyc;
        int          lat;
        int          exp_lat;
        int          pbase;
        int          pb0;
        int          np;
        bit          stable;
        logic [31:0] got;
        logic [31:0] emask;
        logic [31:0] obs_tms;
        logic [31:0] obs_tdi;

        tdo_pat  = pat;
        loopback = lb;
        cyc = 0;
        while (cmd_ready !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_ready"}, cmd_ready, 1);
        if (cmd_ready !== 1'b1) return;

        fall_base  = fall_cnt;
        pbase      = pulses;
        pulse_base = pulses;
        pb0        = phase_bad;
        cmd_valid  = 1'b1;
        cmd_len    = LW'(len);
        cmd_tms    = t_tms;
        cmd_tdi    = t_tdi;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_len   = LW'($urandom);
        cmd_tms   = $urandom;
        cmd_tdi   = $urandom;
        check({tag, "_busy"}, cmd_ready, 0);

        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
        exp_lat = 2 * CLK_DIV * exp_pulses;
        total++;
        if (rsp_valid !== 1'b1 || lat < exp_lat - 1 || lat > exp_lat + 1) begin
            bad++;
            $display("FAIL %s_latency: got %0d cycles expected %0d+/-1", tag, lat, exp_lat);
        end
        got = rsp_tdo;

        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_tdo !== got || cmd_ready !== 1'b0 || tck !== 1'b0)
                stable = 1'b0;
        end
        check({tag, "_hold"}, stable, 1);

        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, "_vld_drop"}, rsp_valid, 0);
        check({tag, "_rdy_back"}, cmd_ready, 1);

        np = pulses - pbase;
        emask = (exp_pulses >= 32) ? 32'hFFFF_FFFF : ((32'd1 << exp_pulses) - 32'd1);
        obs_tms = '0;
        obs_tdi = '0;
        for (int k = 0; k < np && k < 32; k++) begin
            obs_tms[k] = mon_tms[pbase + k];
            obs_tdi[k] = mon_tdi[pbase + k];
        end
        check({tag, "_rsp"}, got, exp_rsp);
        check({tag, "_pulses"}, np, exp_pulses);
        check({tag, "_tms_bits"}, obs_tms, t_tms & emask);
        check({tag, "_tdi_bits"}, obs_tdi, t_tdi & emask);
        check({tag, "_phase"}, phase_bad - pb0, 0);
        check({tag, "_tck_idle"}, tck, 0);
        if (exp_pulses > 0) check({tag, "_tms_hold"}, tms, t_tms[exp_pulses - 1]);
    endtask

    typedef struct {
        int          len;
        logic [31:0] tms;
        logic [31:0] tdi;
        logic [63:0] pat;
        bit          lb;
        int          hold;
        logic [31:0] exp_rsp;
        int          exp_pulses;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int cyc;
        int pbase;
        bit seen;

        vecs[0] = '{5,  32'h0000_001F, 32'h0000_0000, 64'h0,                   1'b0, 0,  32'h0000_0000, 5};
        vecs[1] = '{32, 32'h8000_0000, 32'h0000_0000, 64'h0000_0000_2495_11C3, 1'b0, 0,  32'h2495_11C3, 32};
        vecs[2] = '{7,  32'h0000_0000, 32'hFFFF_FF53, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0,  32'h0000_0053, 7};
        vecs[3] = '{0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0,  32'h0000_0000, 0};
        vecs[4] = '{40, 32'h0000_0000, 32'h0000_0000, 64'hFFFF_FFFF_A5A5_5A5A, 1'b0, 0,  32'hA5A5_5A5A, 32};
        vecs[5] = '{1,  32'h0000_0001, 32'h0000_0001, 64'h0000_0000_0000_0001, 1'b0, 0,  32'h0000_0001, 1};
        vecs[6] = '{9,  32'h0000_0155, 32'h0000_00AA, 64'hFFFF_FFFF_FFFF_F0F3, 1'b0, 10, 32'h0000_00F3, 9};
        vecs[7] = '{33, 32'h1234_5678, 32'h8765_4321, 64'h0000_0001_8000_0001, 1'b0, 2,  32'h8000_0001, 32};
        vecs[8] = '{63, 32'hCAFE_F00D, 32'h0F0F_F0F0, 64'hDEAD_BEEF_1234_5678, 1'b0, 1,  32'h1234_5678, 32};

        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        cmd_tms   = '0;
        cmd_tdi   = '0;
        rsp_ready = 1'b0;
        tdo_pat   = '0;
        loopback  = 1'b0;
        fall_base = 0;
        pulse_base = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tck", tck, 0);
        check("rst_tms", tms, 1);
        check("rst_tdi", tdi, 0);
        check("rst_trst", trst_n, 0);
        check("rst_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_tdo", rsp_tdo, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rel_trst", trst_n, 1);
        check("rel_ready", cmd_ready, 1);

        for (int v = 0; v < 9; v++) begin
            run_cmd($sformatf("vec%0d", v), vecs[v].len, vecs[v].tms, vecs[v].tdi, vecs[v].pat,
                    vecs[v].lb, vecs[v].hold, vecs[v].exp_rsp, vecs[v].exp_pulses);
        end

        for (int r = 0; r < 24; r++) begin
            int          len;
            int          n;
            bit          lb;
            logic [31:0] rt;
            logic [31:0] rd;
            logic [63:0] rp;
            logic [31:0] e;
            len = $urandom_range(0, 40);
            rt  = $urandom;
            rd  = $urandom;
            rp  = {$urandom, $urandom};
            lb  = 1'($urandom_range(0, 1));
            n   = (len > MAX_LEN) ? MAX_LEN : len;
            e   = lb ? rd : rp[31:0];
            if (n < 32) e = e & ((32'd1 << n) - 32'd1);
            run_cmd($sformatf("rand%0d", r), len, rt, rd, rp, lb, $urandom_range(0, 3), e, n);
        end

        tdo_pat    = '1;
        loopback   = 1'b0;
        fall_base  = fall_cnt;
        pbase      = pulses;
        pulse_base = pulses;
        cmd_valid  = 1'b1;
        cmd_len    = LW'(20);
        cmd_tms    = '0;
        cmd_tdi    = '1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cyc = 0;
        while (!((pulses - pbase) >= 13 && tck === 1'b1) && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("mid_reach_bit12", pulses - pbase, 13);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_tck", tck, 0);
        check("mid_tms", tms, 1);
        check("mid_trst", trst_n, 0);
        check("mid_rsp_valid", rsp_valid, 0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        check("mid_no_rsp", seen, 0);
        check("mid_no_pulse", pulses - pbase, 13);
        check("mid_ready", cmd_ready, 1);
        run_cmd("post_rst", 5, 32'h0000_0013, 32'h0000_000A, 64'h0000_0000_0000_0016, 1'b0, 0,
                32'h0000_0016, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
